// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LAT     = 4;
  localparam int unsigned OFF_W       = 4;
  localparam int unsigned IDX_W       = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // One memory-port command as presented for a single cycle
  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Align an address down to the start of its cache block
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'((1 << OFF_W) - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of the shared memory arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvld;
  logic              i_done;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvld;
  logic              d_done;

  logic [DATA_W-1:0] rdata;
  logic [IDX_W-1:0]  rword;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_vld;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rdata_vld,
    output i_gnt, i_rvld, i_done, d_gnt, d_rvld, d_done, rdata, rword,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  // Requesters plus memory view
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rdata_vld,
    input  i_gnt, i_rvld, i_done, d_gnt, d_rvld, d_done, rdata, rword,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory between I-fill and D-fill/write.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  ic_q, ic_d, ic_nxt;
  logic [IDX_W-1:0]  rc_q, rc_d;
  logic              issued_q, issued_d;
  logic              i_gnt_q, d_gnt_q;
  mem_cmd_t          cmd_q, cmd_d;
  logic              win_i, win_d;
  logic              fill_vld, fill_last;

  assign fill_vld  = (state_q == FILL) && bus.mem_rdata_vld;
  assign fill_last = fill_vld && (rc_q == LAST_IDX);
  assign ic_nxt    = ic_q + IDX_W'(1);

  // Round-robin pick: on contention the side that did not go last wins
  always_comb begin
    win_d = bus.d_req && (!bus.i_req || (last_q == OWN_I));
    win_i = bus.i_req && !win_d;
  end

  // State, counters, latched transaction and registered memory/grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_D;
      base_q   <= '0;
      ic_q     <= '0;
      rc_q     <= '0;
      issued_q <= 1'b0;
      cmd_q    <= '0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      base_q   <= base_d;
      ic_q     <= ic_d;
      rc_q     <= rc_d;
      issued_q <= issued_d;
      cmd_q    <= cmd_d;
      i_gnt_q  <= (state_d != IDLE) && (owner_d == OWN_I);
      d_gnt_q  <= (state_d != IDLE) && (owner_d == OWN_D);
    end
  end

  // Next state: grant in IDLE, leave FILL on last return, WRITE lasts one cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (win_d || win_i) begin
          owner_d = win_d ? OWN_D : OWN_I;
          last_d  = win_d ? OWN_D : OWN_I;
          base_d  = block_base(win_d ? bus.d_addr : bus.i_addr);
          state_d = (win_d && bus.d_wr) ? WRITE : FILL;
        end
      end
      FILL:    if (fill_last) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next memory command and counters; the command is presented the cycle after
  always_comb begin
    cmd_d    = '0;
    ic_d     = ic_q;
    rc_d     = rc_q;
    issued_d = issued_q;
    unique case (state_q)
      IDLE: begin
        if (win_d && bus.d_wr) begin
          cmd_d.en    = 1'b1;
          cmd_d.wr    = 1'b1;
          cmd_d.addr  = bus.d_addr;
          cmd_d.wdata = bus.d_wdata;
        end else if (win_d || win_i) begin
          cmd_d.en = 1'b1;
          cmd_d.addr = base_d;
          ic_d     = '0;
          rc_d     = '0;
          issued_d = 1'b0;
        end
      end
      FILL: begin
        if (fill_vld) rc_d = rc_q + IDX_W'(1);
        if (!issued_q) begin
          if (ic_q == LAST_IDX) begin
            issued_d = 1'b1;
          end else begin
            ic_d       = ic_nxt;
            cmd_d.en   = 1'b1;
            cmd_d.addr = base_q | ADDR_W'({ic_nxt, 1'b0});
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = cmd_q.en;
  assign bus.mem_wr    = cmd_q.wr;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;

  // Return path passes straight through so word k arrives MEM_LAT after its issue
  assign bus.i_rvld = fill_vld && (owner_q == OWN_I);
  assign bus.d_rvld = fill_vld && (owner_q == OWN_D);
  assign bus.i_done = fill_last && (owner_q == OWN_I);
  assign bus.d_done = (state_q == WRITE) || (fill_last && (owner_q == OWN_D));
  assign bus.rdata  = fill_vld ? bus.mem_rdata : '0;
  assign bus.rword  = fill_vld ? rc_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [15:0] KEY = 16'h5A3C;
  localparam int TMO = 200;
  localparam int BW  = int'(BLOCK_WORDS);
  localparam int ML  = int'(MEM_LAT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stray = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if ifc();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: fixed MEM_LAT read pipeline, data is address XOR KEY
  logic [MEM_LAT-1:0] pv;
  logic [15:0]        pa [MEM_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < ML; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[MEM_LAT-2:0], ifc.mem_en && !ifc.mem_wr};
      pa[0] <= ifc.mem_addr;
      for (int i = 1; i < ML; i++) pa[i] <= pa[i-1];
    end
  end

  assign ifc.mem_rdata_vld = pv[MEM_LAT-1] | stray;
  assign ifc.mem_rdata     = pv[MEM_LAT-1] ? (pa[MEM_LAT-1] ^ KEY) : 16'hDEAD;

  // Reference model state: one scheduled transaction at a time
  bit          m_busy  = 1'b0;
  int          m_t     = 0;
  int          m_end   = 0;
  owner_e      m_owner = OWN_I;
  owner_e      m_last  = OWN_D;
  logic        m_wr    = 1'b0;
  logic [15:0] m_base  = '0;
  logic [15:0] m_waddr = '0;
  logic [15:0] m_wdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, then advance the model
  task automatic model_cycle();
    logic eig, eir, eid, edg, edr, edd, een, ewr;
    logic [15:0] ead, ewd, erd;
    logic [2:0]  erw;
    int d, k;
    eig = 0; eir = 0; eid = 0; edg = 0; edr = 0; edd = 0; een = 0; ewr = 0;
    ead = '0; ewd = '0; erd = '0; erw = '0;
    if (rst_n && m_busy && cyc <= m_end) begin
      d = cyc - m_t;
      if (m_wr) begin
        edg = 1; een = 1; ewr = 1; ead = m_waddr; ewd = m_wdata; edd = 1;
      end else begin
        if (m_owner == OWN_I) eig = 1; else edg = 1;
        if (d >= 1 && d <= BW) begin
          een = 1;
          ead = m_base + 16'(2 * (d - 1));
        end
        if (d >= 1 + ML && d <= BW + ML) begin
          k   = d - 1 - ML;
          erw = 3'(k);
          erd = (m_base + 16'(2 * k)) ^ KEY;
          if (m_owner == OWN_I) eir = 1; else edr = 1;
          if (d == BW + ML) begin
            if (m_owner == OWN_I) eid = 1; else edd = 1;
          end
        end
      end
    end
    chk("i_gnt",     32'(ifc.i_gnt),     32'(eig));
    chk("i_rvld",    32'(ifc.i_rvld),    32'(eir));
    chk("i_done",    32'(ifc.i_done),    32'(eid));
    chk("d_gnt",     32'(ifc.d_gnt),     32'(edg));
    chk("d_rvld",    32'(ifc.d_rvld),    32'(edr));
    chk("d_done",    32'(ifc.d_done),    32'(edd));
    chk("mem_en",    32'(ifc.mem_en),    32'(een));
    chk("mem_wr",    32'(ifc.mem_wr),    32'(ewr));
    chk("mem_addr",  32'(ifc.mem_addr),  32'(ead));
    chk("mem_wdata", 32'(ifc.mem_wdata), 32'(ewd));
    chk("rdata",     32'(ifc.rdata),     32'(erd));
    chk("rword",     32'(ifc.rword),     32'(erw));
    if (!rst_n) begin
      m_busy = 0;
      m_last = OWN_D;
    end else if ((!m_busy || cyc > m_end) && (ifc.i_req || ifc.d_req)) begin
      if (ifc.i_req && ifc.d_req) m_owner = (m_last == OWN_D) ? OWN_I : OWN_D;
      else                        m_owner = ifc.d_req ? OWN_D : OWN_I;
      m_last  = m_owner;
      m_busy  = 1;
      m_t     = cyc;
      m_wr    = (m_owner == OWN_D) && ifc.d_wr;
      m_base  = (m_owner == OWN_D) ? {ifc.d_addr[15:4], 4'h0} : {ifc.i_addr[15:4], 4'h0};
      m_waddr = ifc.d_addr;
      m_wdata = ifc.d_wdata;
      m_end   = cyc + (m_wr ? 1 : BW + ML);
    end
  endtask

  task automatic wait_i_done(output int dc);
    dc = -1;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (ifc.i_done === 1'b1) begin dc = cyc; break; end
    end
    chk("i_done_wait", 32'(dc >= 0), 32'd1);
  endtask

  task automatic wait_d_done(output int dc);
    dc = -1;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (ifc.d_done === 1'b1) begin dc = cyc; break; end
    end
    chk("d_done_wait", 32'(dc >= 0), 32'd1);
  endtask

  task automatic i_txn(input logic [15:0] addr, output int dc);
    ifc.i_req  = 1;
    ifc.i_addr = addr;
    wait_i_done(dc);
    @(posedge clk); #1;
    ifc.i_req = 0;
  endtask

  task automatic d_txn(input logic [15:0] addr, input logic wr, input logic [15:0] wd, output int dc);
    ifc.d_req   = 1;
    ifc.d_wr    = wr;
    ifc.d_addr  = addr;
    ifc.d_wdata = wd;
    wait_d_done(dc);
    @(posedge clk); #1;
    ifc.d_req = 0;
    ifc.d_wr  = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int ic, dcy;
    ifc.i_req = 0; ifc.i_addr = '0;
    ifc.d_req = 0; ifc.d_wr = 0; ifc.d_addr = '0; ifc.d_wdata = '0;

    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_mem_en", 32'(ifc.mem_en), 32'd0);
    chk("rst_i_gnt",  32'(ifc.i_gnt),  32'd0);
    chk("rst_d_gnt",  32'(ifc.d_gnt),  32'd0);
    @(posedge clk); #1 rst_n = 1;

    // I-side fill of 0x1236
    ifc.i_req  = 1;
    ifc.i_addr = 16'h1236;
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1)  chk("t1_addr0",  32'(ifc.mem_addr), 32'h1230);
      if (k == 4)  chk("t1_rvld4",  32'(ifc.i_rvld),   32'd0);
      if (k == 5)  chk("t1_rvld5",  32'(ifc.i_rvld),   32'd1);
      if (k == 5)  chk("t1_rword0", 32'(ifc.rword),    32'd0);
      if (k == 6)  chk("t1_d_gnt",  32'(ifc.d_gnt),    32'd0);
      if (k == 8)  chk("t1_addr7",  32'(ifc.mem_addr), 32'h123E);
      if (k == 9)  chk("t1_en_off", 32'(ifc.mem_en),   32'd0);
      if (k == 11) chk("t1_nodone", 32'(ifc.i_done),   32'd0);
      if (k == 12) chk("t1_done",   32'(ifc.i_done),   32'd1);
      if (k == 12) chk("t1_rword7", 32'(ifc.rword),    32'd7);
      if (k == 12) chk("t1_rdata7", 32'(ifc.rdata),    32'h4802);
    end
    @(posedge clk); #1 ifc.i_req = 0;
    @(posedge clk); #1;

    // D-side single-word write
    ifc.d_req = 1; ifc.d_wr = 1; ifc.d_addr = 16'h0042; ifc.d_wdata = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("t2_en",    32'(ifc.mem_en),    32'd1);
    chk("t2_wr",    32'(ifc.mem_wr),    32'd1);
    chk("t2_addr",  32'(ifc.mem_addr),  32'h0042);
    chk("t2_wdata", 32'(ifc.mem_wdata), 32'hBEEF);
    chk("t2_done",  32'(ifc.d_done),    32'd1);
    @(posedge clk); #1 ifc.d_req = 0; ifc.d_wr = 0;
    @(negedge clk);
    chk("t2_idle", 32'(ifc.mem_en), 32'd0);

    // Contention after reset: I first, D one IDLE cycle later; then D first
    @(posedge clk); #1;
    do_reset();
    fork
      i_txn(16'h2004, ic);
      d_txn(16'h3008, 1'b1, 16'h1111, dcy);
    join
    chk("rr1_gap", 32'(dcy - ic), 32'd2);
    i_txn(16'h0100, ic);
    fork
      i_txn(16'h0200, ic);
      d_txn(16'h0300, 1'b0, 16'h0000, dcy);
    join
    chk("rr2_gap", 32'(ic - dcy), 32'd13);

    // Reset during the fifth fill issue
    ifc.d_req = 1; ifc.d_wr = 0; ifc.d_addr = 16'h0A0A;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_issue5", 32'(ifc.mem_addr), 32'h0A08);
    rst_n = 0; ifc.d_req = 0;
    #1;
    chk("t4_gnt0",  32'(ifc.d_gnt),    32'd0);
    chk("t4_en0",   32'(ifc.mem_en),   32'd0);
    chk("t4_addr0", 32'(ifc.mem_addr), 32'd0);
    chk("t4_done0", 32'(ifc.d_done),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    d_txn(16'h0A0A, 1'b0, 16'h0000, dcy);

    // Stray return in IDLE must be ignored
    @(posedge clk); #1 stray = 1;
    @(negedge clk);
    chk("t5_i_rvld", 32'(ifc.i_rvld), 32'd0);
    chk("t5_d_rvld", 32'(ifc.d_rvld), 32'd0);
    @(posedge clk); #1 stray = 0;
    i_txn(16'h7770, ic);

    // Held request re-arbitrates with the current address
    ifc.i_req = 1; ifc.i_addr = 16'h4444;
    repeat (4) @(posedge clk);
    #1 ifc.i_addr = 16'h5556;
    wait_i_done(ic);
    @(negedge clk);
    @(negedge clk);
    chk("t6_rebase", 32'(ifc.mem_addr), 32'h5550);
    wait_i_done(ic);
    @(posedge clk); #1 ifc.i_req = 0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
